// File: rtl/dcache_write_buffer.sv
// In-order write buffer between the data cache write-back port and the bridge data_wr port.
// Drains one entry per REQ/GAP/IDLE round and offers a line-address conflict check to the cache.
module dcache_write_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [127:0]             wr_data,
  output logic                     wr_rdy,
  input  logic [31:0]              chk_addr,
  output logic                     chk_hit,
  output logic                     out_wr_req,
  output logic [2:0]               out_wr_type,
  output logic [31:0]              out_wr_addr,
  output logic [3:0]               out_wstrb,
  output logic [127:0]             out_wdata,
  input  logic                     out_wr_rdy,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [2:0]   wtype;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic   full;
  logic   push;
  logic   pop;
  entry_t head_e;
  logic   unused_chk_offset;

  // Occupancy flags depend on the pointers only
  assign full   = (tail_q[AW] != head_q[AW]) && (tail_q[AW-1:0] == head_q[AW-1:0]);
  assign empty  = (tail_q == head_q);
  assign count  = tail_q - head_q;
  assign wr_rdy = !full;

  assign push = wr_req && wr_rdy;
  assign pop  = (state_q == REQ) && out_wr_rdy;

  // Head entry is always presented; the bridge only looks while out_wr_req is high
  assign head_e      = mem_q[head_q[AW-1:0]];
  assign out_wr_type = head_e.wtype;
  assign out_wr_addr = head_e.addr;
  assign out_wstrb   = head_e.wstrb;
  assign out_wdata   = head_e.data;

  assign unused_chk_offset = ^chk_addr[3:0];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[tail_q[AW-1:0]] = '{wtype: wr_type, addr: wr_addr, wstrb: wr_wstrb, data: wr_data};
      tail_d                = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
  end

  // Drain FSM: GAP gives the bridge one cycle to drop its registered rdy
  always_comb begin
    state_d    = state_q;
    out_wr_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) state_d = REQ;
      end
      REQ: begin
        out_wr_req = 1'b1;
        if (out_wr_rdy) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line match over entries still held; a same-cycle push or a popped entry is not visible
  always_comb begin
    logic [AW-1:0] idx;
    chk_hit = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q[AW-1:0] + AW'(i);
      if ((PW'(i) < count) && (mem_q[idx].addr[31:4] == chk_addr[31:4])) begin
        chk_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      mem_q   <= mem_d;
    end
  end

endmodule
